// File: rtl/saa1099_pkg.sv
// Shared definitions for the SAA1099 write-port master: the request payload,
// the bus FSM state encoding and the chip register index map.
package saa1099_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    // One queued register write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } saa_req_t;

    localparam int unsigned REQ_W = $bits(saa_req_t);

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD
    } wr_state_e;

    // SAA1099 register indices.
    localparam logic [ADDR_W-1:0] REG_AMP0     = 5'h00;
    localparam logic [ADDR_W-1:0] REG_FREQ0    = 5'h08;
    localparam logic [ADDR_W-1:0] REG_OCT10    = 5'h10;
    localparam logic [ADDR_W-1:0] REG_FREQEN   = 5'h14;
    localparam logic [ADDR_W-1:0] REG_NOISEEN  = 5'h15;
    localparam logic [ADDR_W-1:0] REG_NOISEGEN = 5'h16;
    localparam logic [ADDR_W-1:0] REG_ENV0     = 5'h18;
    localparam logic [ADDR_W-1:0] REG_ENV1     = 5'h19;
    localparam logic [ADDR_W-1:0] REG_CTRL     = 5'h1C;

endpackage

// File: rtl/saa1099_wr_fifo.sv
// Synchronous first-word-fall-through FIFO for queued register writes.
// Ports:
//   clk_sys, rst_n  clock, async active-low reset (empties the FIFO)
//   push, wdata     write side; push is ignored while full
//   pop, rdata      read side; rdata shows the head entry, pop is ignored while empty
//   full, empty     status decoded from the registered occupancy
//   level           current occupancy, 0..DEPTH
module saa1099_wr_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/saa1099_writer.sv
// Bus master for the SAA1099 CPU write port. Buffers valid/ready register
// writes and turns each into an address cycle (a0=1, skipped when the chip
// already has that register latched) followed by a data cycle (a0=0).
// Ports:
//   clk_sys, rst_n             clock, async active-low reset
//   req_valid/req_ready        request handshake (ready = FIFO not full)
//   req_addr, req_data         register index and value
//   inval                      forget the latched-address cache
//   busy                       work queued or bus cycle in progress
//   level                      FIFO occupancy
//   cs_n, a0, wr_n, dout       registered SAA1099 bus pins
module saa1099_writer
    import saa1099_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STROBE_LEN = 2,
    parameter int unsigned GAP_LEN    = 2
) (
    input  logic                          clk_sys,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_data,
    input  logic                          inval,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          cs_n,
    output logic                          a0,
    output logic                          wr_n,
    output logic [DATA_W-1:0]             dout
);

    localparam int unsigned MAX_LEN = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_LEN - 1);

    wr_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    saa_req_t           work, work_nxt;
    logic [ADDR_W-1:0]  cache_addr, cache_addr_nxt;
    logic               cache_vld, cache_vld_nxt;
    logic               cs_n_nxt, a0_nxt, wr_n_nxt;
    logic [DATA_W-1:0]  dout_nxt;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REQ_W-1:0]   fifo_rdata;
    saa_req_t           head;
    logic               cache_hit_c;

    assign fifo_push   = req_valid && !fifo_full;
    assign req_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state != IDLE);
    assign head        = saa_req_t'(fifo_rdata);
    assign cache_hit_c = cache_vld && (cache_addr == head.addr);

    saa1099_wr_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wdata   (REQ_W'({req_addr, req_data})),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Next-state, counter, cache and next-pin values. Pins are decoded from
    // the next state so every bus pin comes straight from a flop.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        work_nxt       = work;
        cache_addr_nxt = cache_addr;
        cache_vld_nxt  = cache_vld;
        fifo_pop       = 1'b0;
        cs_n_nxt       = cs_n;
        a0_nxt         = a0;
        wr_n_nxt       = wr_n;
        dout_nxt       = dout;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    work_nxt  = head;
                    state_nxt = cache_hit_c ? D_SETUP : A_SETUP;
                end
            end
            A_SETUP: begin
                state_nxt = A_STROBE;
                cnt_nxt   = STROBE_LOAD;
            end
            A_STROBE: begin
                if (cnt == '0) begin
                    state_nxt      = A_HOLD;
                    cnt_nxt        = GAP_LOAD;
                    cache_addr_nxt = work.addr;
                    cache_vld_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            A_HOLD: begin
                if (cnt == '0) state_nxt = D_SETUP;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            D_SETUP: begin
                state_nxt = D_STROBE;
                cnt_nxt   = STROBE_LOAD;
            end
            D_STROBE: begin
                if (cnt == '0) begin
                    state_nxt = D_HOLD;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            D_HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // Invalidate beats a same-cycle cache fill.
        if (inval) cache_vld_nxt = 1'b0;

        // a0/dout only move on entry to a SETUP state, so they are stable
        // through the strobe and the hold that follows it.
        case (state_nxt)
            IDLE: begin
                cs_n_nxt = 1'b1;
                wr_n_nxt = 1'b1;
            end
            A_SETUP: begin
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b1;
                a0_nxt   = 1'b1;
                dout_nxt = DATA_W'(work_nxt.addr);
            end
            D_SETUP: begin
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b1;
                a0_nxt   = 1'b0;
                dout_nxt = work_nxt.data;
            end
            A_STROBE, D_STROBE: begin
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b0;
            end
            A_HOLD, D_HOLD: begin
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b1;
            end
            default: begin
                cs_n_nxt = 1'b1;
                wr_n_nxt = 1'b1;
            end
        endcase
    end

    // State, counter, cache and bus pin registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            work       <= '0;
            cache_addr <= '0;
            cache_vld  <= 1'b0;
            cs_n       <= 1'b1;
            a0         <= 1'b0;
            wr_n       <= 1'b1;
            dout       <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            work       <= work_nxt;
            cache_addr <= cache_addr_nxt;
            cache_vld  <= cache_vld_nxt;
            cs_n       <= cs_n_nxt;
            a0         <= a0_nxt;
            wr_n       <= wr_n_nxt;
            dout       <= dout_nxt;
        end
    end

endmodule

// File: tb/tb_saa1099_writer.sv
// Scoreboard bench for saa1099_writer. Instance 0 uses default timing,
// instance 1 uses STROBE_LEN=3 / GAP_LEN=1 for random protocol traffic.
module tb_saa1099_writer;

    localparam int unsigned S0 = 2;
    localparam int unsigned G0 = 2;
    localparam int unsigned S1 = 3;
    localparam int unsigned G1 = 1;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       req_valid [2];
    logic       req_ready [2];
    logic [4:0] req_addr  [2];
    logic [7:0] req_data  [2];
    logic       inval     [2];
    logic       busy      [2];
    logic [2:0] level     [2];
    logic       cs_n      [2];
    logic       a0        [2];
    logic       wr_n      [2];
    logic [7:0] dout      [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scoreboard: expected strobes {a0, dout} and expected cs_n-low burst lengths.
    logic [8:0] exp_q [2][$];
    int         bq    [2][$];
    logic [4:0] m_cache [2];
    bit         m_vld   [2];

    // Monitor state.
    logic       prev_wr   [2];
    logic       prev_a0   [2];
    logic [7:0] prev_dout [2];
    int         cs_len    [2];
    bit         saw_full;

    // Receiver model for instance 0.
    logic [7:0] rx_reg [32];
    logic [4:0] rx_addr;
    logic       rx_prev_wr;
    bit         rx_pend;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    saa1099_writer #(.FIFO_DEPTH(4), .STROBE_LEN(S0), .GAP_LEN(G0)) dut0 (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]), .inval(inval[0]),
        .busy(busy[0]), .level(level[0]),
        .cs_n(cs_n[0]), .a0(a0[0]), .wr_n(wr_n[0]), .dout(dout[0])
    );

    saa1099_writer #(.FIFO_DEPTH(4), .STROBE_LEN(S1), .GAP_LEN(G1)) dut1 (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]), .inval(inval[1]),
        .busy(busy[1]), .level(level[1]),
        .cs_n(cs_n[1]), .a0(a0[1]), .wr_n(wr_n[1]), .dout(dout[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int phase_len(input int i);
        return (i == 0) ? int'(1 + S0 + G0) : int'(1 + S1 + G1);
    endfunction

    // Bus monitor: pops the scoreboard on every wr_n fall, checks burst
    // lengths when cs_n rises and checks a0/dout stability around strobes.
    always @(negedge clk_sys) begin
        logic [8:0] e;
        int         b;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                prev_wr[i] = 1'b1;
                cs_len[i]  = 0;
            end else begin
                if (prev_wr[i] && !wr_n[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe%0d: unexpected strobe a0=%0b dout=0x%0h", i, a0[i], dout[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("strobe%0d a0/dout", i), 32'({a0[i], dout[i]}), 32'(e));
                        chk($sformatf("strobe%0d cs_n", i), 32'(cs_n[i]), 32'd0);
                    end
                end
                if (!prev_wr[i])
                    chk($sformatf("stable%0d a0/dout", i), 32'({a0[i], dout[i]}),
                        32'({prev_a0[i], prev_dout[i]}));
                if (!cs_n[i]) begin
                    cs_len[i]++;
                end else if (cs_len[i] > 0) begin
                    if (bq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL burst%0d: unexpected cs_n burst of %0d cycles", i, cs_len[i]);
                    end else begin
                        b = bq[i].pop_front();
                        chk($sformatf("burst%0d length", i), 32'(cs_len[i]), 32'(b));
                    end
                    cs_len[i] = 0;
                end
                prev_wr[i]   = wr_n[i];
                prev_a0[i]   = a0[i];
                prev_dout[i] = dout[i];
            end
        end
        if (rst_n && !req_ready[0]) begin
            chk("ready low only when full", 32'(level[0]), 32'd4);
            if (level[0] == 3'd4) saw_full = 1'b1;
        end
    end

    // Chip-side receiver: samples a0/din one cycle after wr_n rises.
    always @(negedge clk_sys) begin
        if (!rst_n) begin
            rx_pend    = 1'b0;
            rx_prev_wr = 1'b1;
        end else begin
            if (rx_pend) begin
                if (a0[0]) rx_addr = dout[0][4:0];
                else       rx_reg[rx_addr] = dout[0];
            end
            rx_pend    = !rx_prev_wr && wr_n[0];
            rx_prev_wr = wr_n[0];
        end
    end

    // Queue expectations for one request, then complete the handshake.
    // Called and returns 1 time unit after a rising edge.
    task automatic push(input int i, input logic [4:0] a, input logic [7:0] d);
        bit hit;
        int n;
        hit = m_vld[i] && (m_cache[i] == a);
        if (!hit) exp_q[i].push_back({1'b1, 3'b000, a});
        exp_q[i].push_back({1'b0, d});
        bq[i].push_back(hit ? phase_len(i) : 2 * phase_len(i));
        m_cache[i] = a;
        m_vld[i]   = 1'b1;
        req_addr[i]  = a;
        req_data[i]  = d;
        req_valid[i] = 1'b1;
        n = 0;
        while (!req_ready[i] && n < 400) begin
            @(posedge clk_sys); #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL push%0d: req_ready stuck low", i);
        end
        @(posedge clk_sys); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] && n < 400) begin
            @(posedge clk_sys); #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL idle%0d: busy stuck high", i);
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic pulse_inval0();
        inval[0] = 1'b1;
        @(posedge clk_sys); #1;
        inval[0] = 1'b0;
        m_vld[0] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t_cs;
        bit seen_low;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            req_data[i]  = '0;
            inval[i]     = 1'b0;
            m_vld[i]     = 1'b0;
            m_cache[i]   = '0;
            prev_wr[i]   = 1'b1;
            cs_len[i]    = 0;
        end
        for (int r = 0; r < 32; r++) rx_reg[r] = '0;
        rx_addr  = '0;
        saw_full = 1'b0;

        // Reset values.
        rst_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst cs_n", 32'(cs_n[0]), 32'd1);
        chk("rst wr_n", 32'(wr_n[0]), 32'd1);
        chk("rst a0", 32'(a0[0]), 32'd0);
        chk("rst dout", 32'(dout[0]), 32'd0);
        chk("rst req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst busy", 32'(busy[0]), 32'd0);
        chk("rst level", 32'(level[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk_sys); #1;

        // Single write, with latency checks: push in cycle 0.
        push(0, 5'h14, 8'h3F);
        chk("lat c1 level", 32'(level[0]), 32'd1);
        chk("lat c1 cs_n", 32'(cs_n[0]), 32'd1);
        chk("lat c1 busy", 32'(busy[0]), 32'd1);
        @(posedge clk_sys); #1;
        chk("lat c2 cs_n", 32'(cs_n[0]), 32'd0);
        chk("lat c2 a0", 32'(a0[0]), 32'd1);
        chk("lat c2 dout", 32'(dout[0]), 32'h14);
        chk("lat c2 wr_n", 32'(wr_n[0]), 32'd1);
        @(posedge clk_sys); #1;
        chk("lat c3 wr_n", 32'(wr_n[0]), 32'd0);
        wait_idle(0);
        chk("freqenable", 32'(rx_reg[5'h14]), 32'h3F);

        // Two writes to the same register: miss then hit, 17 cycles total.
        push(0, 5'h08, 8'h10);
        push(0, 5'h08, 8'h20);
        t_cs = -1;
        n = 0;
        while (busy[0] && n < 400) begin
            if (!cs_n[0] && t_cs < 0) t_cs = cyc;
            @(posedge clk_sys); #1;
            n++;
        end
        chk("bus time 2x FREQ0", 32'(cyc - t_cs + 1), 32'd17);
        @(posedge clk_sys); #1;
        chk("FREQ0 value", 32'(rx_reg[5'h08]), 32'h20);

        // Hit, invalidate, then the same register again needs an address cycle.
        push(0, 5'h08, 8'hAA);
        wait_idle(0);
        pulse_inval0();
        push(0, 5'h08, 8'hBB);
        wait_idle(0);

        // inval during A_HOLD still forces the next address cycle.
        push(0, 5'h1C, 8'h01);
        n = 0;
        seen_low = 1'b0;
        while (!(seen_low && wr_n[0] && a0[0] && !cs_n[0]) && n < 100) begin
            seen_low = !wr_n[0];
            @(posedge clk_sys); #1;
            n++;
        end
        chk("reach A_HOLD", 32'(n < 100), 32'd1);
        pulse_inval0();
        wait_idle(0);
        push(0, 5'h1C, 8'h02);
        wait_idle(0);

        // Six back-to-back requests through a 4-deep FIFO.
        push(0, 5'h00, 8'h11);
        push(0, 5'h00, 8'h22);
        push(0, 5'h08, 8'h33);
        push(0, 5'h10, 8'h44);
        push(0, 5'h10, 8'h55);
        push(0, 5'h18, 8'h66);
        n = 0;
        while (busy[0] && n < 400) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("burst busy fall", 32'(n < 400), 32'd1);
        chk("busy fall cs_n", 32'(cs_n[0]), 32'd1);
        chk("busy fall strobes left", 32'(exp_q[0].size()), 32'd0);
        @(posedge clk_sys); #1;
        chk("busy fall bursts left", 32'(bq[0].size()), 32'd0);
        chk("ready dropped when full", 32'(saw_full), 32'd1);
        chk("ENV0 value", 32'(rx_reg[5'h18]), 32'h66);

        // Asynchronous reset during D_STROBE with a second request queued.
        push(0, 5'h19, 8'h55);
        push(0, 5'h1A, 8'h66);
        n = 0;
        while (!(!wr_n[0] && !a0[0]) && n < 100) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("reach D_STROBE", 32'(n < 100), 32'd1);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            bq[i].delete();
            m_vld[i] = 1'b0;
        end
        #1;
        chk("async rst wr_n", 32'(wr_n[0]), 32'd1);
        chk("async rst cs_n", 32'(cs_n[0]), 32'd1);
        chk("async rst level", 32'(level[0]), 32'd0);
        chk("async rst busy", 32'(busy[0]), 32'd0);
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        @(posedge clk_sys); #1;
        push(0, 5'h19, 8'h77);
        wait_idle(0);

        // Random traffic on the STROBE_LEN=3 / GAP_LEN=1 instance.
        for (int k = 0; k < 24; k++) begin
            logic [4:0] a;
            case ($urandom_range(0, 2))
                0:       a = 5'h00;
                1:       a = 5'h08;
                default: a = 5'h1C;
            endcase
            push(1, a, 8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk_sys);
            #0;
        end
        wait_idle(1);
        chk("random strobes left", 32'(exp_q[1].size()), 32'd0);
        chk("random bursts left", 32'(bq[1].size()), 32'd0);
        chk("random level", 32'(level[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
